// File: rtl/mcs4_bus_initiator.sv
// MCS-4 bus initiator: drives the 8-phase instruction cycle so a host can read
// ROM bytes and write/read i4002 RAM characters and output ports.
module mcs4_bus_initiator #(
  parameter int RAM_BANK  = 2,
  parameter bit IDLE_SYNC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  dbus_in,
  output logic [3:0]  dbus_out,
  output logic        sync,
  output logic        cm_rom,
  output logic [3:0]  cm_ram,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [11:0] cmd_addr,
  input  logic [3:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data
);
  localparam logic [2:0] A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
                         M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7;
  localparam logic [1:0] OP_ROM_READ = 2'd0, OP_RAM_WRITE = 2'd1,
                         OP_RAM_READ = 2'd2;
  localparam logic [3:0] BANK_MASK = 4'(1 << RAM_BANK);

  // ARMED holds an accepted command until the next cycle boundary.
  typedef enum logic [2:0] {IDLE, ARMED, ROM_CYC, SRC_CYC, IO_CYC} state_t;

  state_t      state, state_nx;
  logic [2:0]  phase;
  logic [1:0]  op;
  logic [11:0] addr;
  logic [3:0]  wdata;
  logic [7:0]  rsp_q;
  logic        accept;
  logic [3:0]  io_opa;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ready = (state == IDLE);
  assign rsp_data  = rsp_q;

  // Free-running bus phase, A1..X3.
  always_ff @(posedge clk) begin
    if (rst) phase <= A1;
    else     phase <= phase + 3'd1;
  end

  // Capture the command on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      op    <= 2'd0;
      addr  <= 12'd0;
      wdata <= 4'd0;
    end else if (accept) begin
      op    <= cmd_op;
      addr  <= cmd_addr;
      wdata <= cmd_wdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Read data capture: OPR/OPA in ROM M1/M2, RAM character in IO X2.
  always_ff @(posedge clk) begin
    if (rst) rsp_q <= 8'd0;
    else if (state == ROM_CYC && phase == M1) rsp_q[7:4] <= dbus_in;
    else if (state == ROM_CYC && phase == M2) rsp_q[3:0] <= dbus_in;
    else if (state == IO_CYC && op == OP_RAM_READ && phase == X2)
      rsp_q <= {4'h0, dbus_in};
  end

  always_comb begin
    case (op)
      OP_RAM_WRITE: io_opa = 4'h0;  // WRM
      OP_RAM_READ:  io_opa = 4'h9;  // RDM
      default:      io_opa = 4'h1;  // WMP
    endcase
  end

  // Next state and per-phase bus drive.
  always_comb begin
    state_nx  = state;
    dbus_out  = 4'h0;
    sync      = 1'b0;
    cm_rom    = 1'b0;
    cm_ram    = 4'h0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        sync = IDLE_SYNC && (phase == X3);
        if (accept) begin
          if (phase == X3) state_nx = (cmd_op == OP_ROM_READ) ? ROM_CYC : SRC_CYC;
          else             state_nx = ARMED;
        end
      end
      ARMED: begin
        sync = IDLE_SYNC && (phase == X3);
        if (phase == X3) state_nx = (op == OP_ROM_READ) ? ROM_CYC : SRC_CYC;
      end
      ROM_CYC: begin
        sync = (phase == X3);
        case (phase)
          A1: dbus_out = addr[3:0];
          A2: dbus_out = addr[7:4];
          A3: begin dbus_out = addr[11:8]; cm_rom = 1'b1; end
          X1: rsp_valid = 1'b1;
          default: ;
        endcase
        if (phase == X3) state_nx = IDLE;
      end
      SRC_CYC: begin
        sync = (phase == X3);
        // ROMs stay unselected, so the initiator owns the M phases.
        case (phase)
          M1: dbus_out = 4'h2;
          M2: dbus_out = 4'h1;
          X2: begin dbus_out = addr[7:4]; cm_ram = BANK_MASK; end
          X3: dbus_out = addr[3:0];
          default: ;
        endcase
        if (phase == X3) state_nx = IO_CYC;
      end
      IO_CYC: begin
        sync = (phase == X3);
        case (phase)
          M1: dbus_out = 4'hE;
          M2: begin dbus_out = io_opa; cm_ram = BANK_MASK; end
          X2: dbus_out = (op == OP_RAM_READ) ? 4'h0 : wdata;
          X3: rsp_valid = (op == OP_RAM_READ);
          default: ;
        endcase
        if (phase == X3) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mcs4_bus_initiator.sv
// Bench for mcs4_bus_initiator: behavioural i4001/i4002 bus devices, a
// data-level reference model and per-clock bus trace checks.
module tb_mcs4_bus_initiator;
  localparam int BANK = 2;
  localparam logic [3:0] MASK = 4'(1 << BANK);

  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  dbus_in, dbus_out, cm_ram, dev_drv;
  logic        sync, cm_rom, cmd_ready, rsp_valid;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [11:0] cmd_addr = 12'd0;
  logic [3:0]  cmd_wdata = 4'd0;
  logic [7:0]  rsp_data;

  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  mcs4_bus_initiator #(.RAM_BANK(BANK), .IDLE_SYNC(1'b1)) dut (
    .clk(clk), .rst(rst), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .sync(sync), .cm_rom(cm_rom), .cm_ram(cm_ram),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data));

  // Bus devices: one i4001-like ROM and one i4002-like RAM/port chip set.
  logic [2:0]  ph;
  logic [7:0]  rom [0:4095];
  logic [11:0] rom_adr;
  logic        rom_sel, io_act, src_flag;
  logic [3:0]  io_opa;
  logic [7:0]  src;
  logic [3:0]  mem [0:255];
  logic [3:0]  port [0:3];

  always @(posedge clk) begin
    if (rst) begin
      ph <= 3'd0; rom_sel <= 1'b0; io_act <= 1'b0; src_flag <= 1'b0;
      src <= 8'd0; io_opa <= 4'd0; rom_adr <= 12'd0;
      for (int i = 0; i < 256; i++) mem[i] <= 4'd0;
      for (int i = 0; i < 4; i++) port[i] <= 4'd0;
    end else begin
      ph <= sync ? 3'd0 : ph + 3'd1;
      case (ph)
        3'd0: rom_adr[3:0] <= dbus_out;
        3'd1: rom_adr[7:4] <= dbus_out;
        3'd2: begin rom_adr[11:8] <= dbus_out; rom_sel <= cm_rom; end
        3'd4: begin io_act <= cm_ram[BANK]; io_opa <= dbus_out; end
        3'd6: begin
          if (io_act) begin
            if (io_opa == 4'h0)      mem[src] <= dbus_out;
            else if (io_opa == 4'h1) port[src[7:6]] <= dbus_out;
          end else if (cm_ram[BANK]) begin
            src[7:4] <= dbus_out; src_flag <= 1'b1;
          end
        end
        3'd7: if (src_flag) begin src[3:0] <= dbus_out; src_flag <= 1'b0; end
        default: ;
      endcase
    end
  end

  assign dev_drv = (rom_sel && ph == 3'd3) ? rom[rom_adr][7:4] :
                   (rom_sel && ph == 3'd4) ? rom[rom_adr][3:0] :
                   (io_act && io_opa == 4'h9 && ph == 3'd6) ? mem[src] : 4'h0;
  assign dbus_in = dbus_out | dev_drv;

  // Reference model at data level.
  logic [3:0] ref_mem [0:255];
  logic [3:0] ref_port [0:3];

  task automatic clear_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = 4'd0;
    for (int i = 0; i < 4; i++) ref_port[i] = 4'd0;
  endtask

  // Checks every clock from acceptance until cmd_ready returns.
  task automatic trace(input logic [1:0] op, input logic [11:0] a,
                       input logic [3:0] wd, input int p,
                       input logic [7:0] ersp, input string nm);
    int n0, len;
    n0  = 8 - p;
    len = (op == 2'd0) ? 8 : 16;
    for (int n = 1; n <= n0 + len; n++) begin
      logic [3:0] ed, ec;
      logic es, er, ev, erdy;
      logic [11:0] got, expv;
      int j, q;
      @(negedge clk);
      j = n - n0; q = (p + n) % 8;
      ed = 4'h0; ec = 4'h0; er = 1'b0; ev = 1'b0;
      es = (q == 7); erdy = (n == n0 + len);
      if (j >= 0 && j < len) begin
        if (op == 2'd0) begin
          case (q)
            0: ed = a[3:0];
            1: ed = a[7:4];
            2: begin ed = a[11:8]; er = 1'b1; end
            5: ev = 1'b1;
            default: ;
          endcase
        end else if (j < 8) begin
          case (q)
            3: ed = 4'h2;
            4: ed = 4'h1;
            6: begin ed = a[7:4]; ec = MASK; end
            7: ed = a[3:0];
            default: ;
          endcase
        end else begin
          case (q)
            3: ed = 4'hE;
            4: begin ed = (op == 2'd1) ? 4'h0 : (op == 2'd2) ? 4'h9 : 4'h1; ec = MASK; end
            6: ed = (op == 2'd2) ? 4'h0 : wd;
            7: ev = (op == 2'd2);
            default: ;
          endcase
        end
      end
      got  = {dbus_out, sync, cm_rom, cm_ram, rsp_valid, cmd_ready};
      expv = {ed, es, er, ec, ev, erdy};
      checks++;
      if (got !== expv)
        $display("FAIL %s clk%0d bus{dbus,sync,cmrom,cmram,rspv,rdy} got %h want %h", nm, n, got, expv);
      else passed++;
      if (ev) begin
        checks++;
        if (rsp_data !== ersp) $display("FAIL %s rsp_data got %h want %h", nm, rsp_data, ersp);
        else passed++;
      end
    end
  endtask

  task automatic wait_ready(input string nm, output int p);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL %s ready timeout got %b want 1", nm, cmd_ready);
    else passed++;
    p = int'(ph);
  endtask

  function automatic logic [7:0] exp_rsp(input logic [1:0] op, input logic [11:0] a);
    if (op == 2'd0) return rom[a];
    return {4'h0, ref_mem[a[7:0]]};
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [11:0] a,
                        input logic [3:0] wd, input string nm);
    int p;
    wait_ready(nm, p);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd;
    @(posedge clk); #1 cmd_valid = 1'b0;
    trace(op, a, wd, p, exp_rsp(op, a), nm);
    if (op == 2'd1) ref_mem[a[7:0]] = wd;
    if (op == 2'd3) ref_port[a[7:6]] = wd;
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if ({dbus_out, sync, cm_rom, cm_ram, rsp_valid, cmd_ready, rsp_data} !== {12'h001, 8'h00})
      $display("FAIL %s outputs got %h want %h", nm,
               {dbus_out, sync, cm_rom, cm_ram, rsp_valid, cmd_ready, rsp_data}, {12'h001, 8'h00});
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    clear_ref();
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int cnt, first, last;
    cnt = 0; first = -1; last = -1;
    for (int n = 0; n < 24; n++) begin
      if (n > 0) @(negedge clk);
      checks++;
      if ({dbus_out, cm_rom, cm_ram, sync} !== {9'h000, (ph == 3'd7)})
        $display("FAIL idle clk%0d got %h want %h", n, {dbus_out, cm_rom, cm_ram, sync}, {9'h000, (ph == 3'd7)});
      else passed++;
      if (sync) begin cnt++; if (first < 0) first = n; last = n; end
    end
    checks++;
    if (cnt != 3 || last - first != 16 || first != 7)
      $display("FAIL idle_sync_period got count %0d first %0d span %0d want 3 7 16", cnt, first, last - first);
    else passed++;
  endtask

  task automatic test_rom();
    do_cmd(2'd0, 12'h003, 4'h0, "rom_003");
    do_cmd(2'd0, 12'hFFF, 4'h0, "rom_fff");
    do_cmd(2'd0, 12'hA5C, 4'h0, "rom_a5c");
  endtask

  task automatic test_ram();
    do_cmd(2'd1, 12'h025, 4'hA, "ram_wr_25");
    do_cmd(2'd2, 12'h025, 4'h0, "ram_rd_25");
    checks++;
    if (rsp_data !== 8'h0A) $display("FAIL ram_rd_25_value got %h want 0a", rsp_data);
    else passed++;
    do_cmd(2'd2, 12'h0FF, 4'h0, "ram_rd_unwritten");
  endtask

  task automatic test_port();
    do_cmd(2'd3, 12'h000, 4'h6, "port_wr_0");
    checks++;
    if (port[0] !== 4'h6) $display("FAIL port0 io_out got %h want 6", port[0]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int p, p2;
    wait_ready("b2b_first", p);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 12'h03C; cmd_wdata = 4'h5;
    @(posedge clk); #1;
    cmd_op = 2'd2; cmd_addr = 12'h0C3; cmd_wdata = 4'hF;
    trace(2'd1, 12'h03C, 4'h5, p, 8'h00, "b2b_first");
    ref_mem[8'h3C] = 4'h5;
    p2 = int'(ph);
    checks++;
    if (p2 != 0) $display("FAIL b2b_ready_phase got %0d want 0", p2);
    else passed++;
    @(posedge clk); #1 cmd_valid = 1'b0;
    trace(2'd2, 12'h0C3, 4'hF, p2, exp_rsp(2'd2, 12'h0C3), "b2b_second");
    do_cmd(2'd2, 12'h03C, 4'h0, "b2b_readback");
  endtask

  task automatic test_reset_mid();
    int p, n0;
    wait_ready("mid_rst", p);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 12'h0F7; cmd_wdata = 4'h9;
    @(posedge clk); #1 cmd_valid = 1'b0;
    n0 = 8 - p;
    for (int n = 1; n <= n0 + 6; n++) @(negedge clk);
    checks++;
    if ({dbus_out, cm_ram} !== {4'hF, MASK})
      $display("FAIL mid_rst_at_x2 got %h want %h", {dbus_out, cm_ram}, {4'hF, MASK});
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    clear_ref();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, dbus_out, cmd_ready} !== 6'b000001)
        $display("FAIL mid_rst_quiet clk%0d got %b want 000001", n, {rsp_valid, dbus_out, cmd_ready});
      else passed++;
    end
    do_cmd(2'd0, 12'h003, 4'h0, "mid_rst_rom");
    do_cmd(2'd2, 12'h0F7, 4'h0, "mid_rst_aborted_wr");
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      logic [1:0]  op;
      logic [11:0] a;
      logic [3:0]  wd;
      op = 2'($urandom_range(0, 3));
      a  = 12'($urandom);
      wd = 4'($urandom);
      if (op == 2'd2 && ($urandom_range(0, 1) == 1)) a[7:0] = 8'h25;
      do_cmd(op, a, wd, $sformatf("rand%0d_op%0d", k, op));
      if (op == 2'd3) begin
        checks++;
        if (port[a[7:6]] !== ref_port[a[7:6]])
          $display("FAIL rand%0d_port got %h want %h", k, port[a[7:6]], ref_port[a[7:6]]);
        else passed++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[3] = 8'hD5;
    test_reset();
    test_idle();
    test_rom();
    test_ram();
    test_port();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
